// File: rtl/pow2_scaler.sv
// Power-of-two scaler: divides (optionally rounding half up) or multiplies an
// unsigned operand by 2^e, one bit position per clock, with multiply saturation.
module pow2_scaler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXP_WIDTH  = 5
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic                  in_mode,
  input  logic                  in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state;
  logic [EXP_WIDTH-1:0] cnt;
  logic                 mode_q;
  logic                 round_q;
  logic                 accept_c;
  logic                 last_shift_c;
  logic                 sat_next_c;

  // Ready in IDLE, or in HOLD when the held result is being consumed this edge.
  assign in_ready = axis_resetn &&
                    ((state == IDLE) || ((state == HOLD) && out_ready));

  assign accept_c     = in_valid && in_ready;
  assign last_shift_c = (cnt == EXP_WIDTH'(1));
  // Sticky overflow including the bit leaving the MSB on this shift.
  assign sat_next_c   = out_sat | out_data[DATA_WIDTH-1];

  // Control FSM and shift datapath; out_data doubles as the working register.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      round_q   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (accept_c) begin
      out_data <= in_data;
      mode_q   <= in_mode;
      round_q  <= in_round;
      cnt      <= in_exp;
      out_sat  <= 1'b0;
      if (in_exp != '0) begin
        state     <= SHIFT;
        out_valid <= 1'b0;
      end else begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        SHIFT: begin
          cnt <= cnt - EXP_WIDTH'(1);
          if (mode_q) begin
            out_sat <= sat_next_c;
            if (last_shift_c && sat_next_c) begin
              out_data <= '1;
            end else begin
              out_data <= out_data << 1;
            end
          end else if (last_shift_c && round_q) begin
            // Top bit of the result is clear after the shift, so the add cannot wrap.
            out_data <= (out_data >> 1) + DATA_WIDTH'(out_data[0]);
          end else begin
            out_data <= out_data >> 1;
          end
          if (last_shift_c) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
